// File: rtl/spi_accel_pkg.sv
// Shared definitions for the ADXL345-style SPI responder: register map, reset values, FSM states.
package spi_accel_pkg;

  localparam logic [5:0] ADDR_DEVID       = 6'h00;
  localparam logic [5:0] ADDR_BW_RATE     = 6'h2C;
  localparam logic [5:0] ADDR_POWER_CTL   = 6'h2D;
  localparam logic [5:0] ADDR_INT_ENABLE  = 6'h2E;
  localparam logic [5:0] ADDR_INT_SOURCE  = 6'h30;
  localparam logic [5:0] ADDR_DATA_FORMAT = 6'h31;
  localparam logic [5:0] ADDR_DATAX0      = 6'h32;
  localparam logic [5:0] ADDR_DATAX1      = 6'h33;
  localparam logic [5:0] ADDR_DATAY0      = 6'h34;
  localparam logic [5:0] ADDR_DATAY1      = 6'h35;
  localparam logic [5:0] ADDR_DATAZ0      = 6'h36;
  localparam logic [5:0] ADDR_DATAZ1      = 6'h37;

  localparam logic [7:0] RST_BW_RATE     = 8'h0A;
  localparam logic [7:0] RST_POWER_CTL   = 8'h00;
  localparam logic [7:0] RST_INT_ENABLE  = 8'h00;
  localparam logic [7:0] RST_DATA_FORMAT = 8'h00;

  localparam int unsigned POWER_CTL_MEASURE_BIT = 3;
  localparam int unsigned INT_DATA_READY_BIT    = 7;

  typedef enum logic [1:0] {
    StIdle,
    StCmd,
    StData
  } state_e;

  function automatic logic is_data_addr(input logic [5:0] addr);
    return (addr >= ADDR_DATAX0) && (addr <= ADDR_DATAZ1);
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// N-stage synchroniser with optional rise/fall pulses taken from the last two synchronised samples.
module spi_sync_edge #(
  parameter int unsigned Stages   = 2,
  parameter bit          ResetVal = 1'b0,
  parameter bit          EdgeEn   = 1'b1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic [Stages-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= {Stages{ResetVal}};
      prev_q <= ResetVal;
    end else begin
      sync_q <= {sync_q[Stages-2:0], d_i};
      prev_q <= sync_q[Stages-1];
    end
  end

  assign q_o    = sync_q[Stages-1];
  assign rise_o = EdgeEn & q_o & ~prev_q;
  assign fall_o = EdgeEn & ~q_o & prev_q;

endmodule

// File: rtl/spi_accel_responder.sv
// Mode-3 SPI responder emulating an ADXL345 register map, oversampled from the system clock.
module spi_accel_responder
  import spi_accel_pkg::*;
#(
  parameter logic [7:0]  DEVID       = 8'hE5,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        spi_csn,
  input  logic        spi_sclk,
  input  logic        spi_sdi,
  output logic        spi_sdo,
  output logic        spi_sdo_oe,
  input  logic [15:0] sample_x,
  input  logic [15:0] sample_y,
  input  logic [15:0] sample_z,
  input  logic        sample_valid,
  output logic        int1,
  output logic [7:0]  cfg_bw_rate,
  output logic [7:0]  cfg_power_ctl,
  output logic [7:0]  cfg_int_enable,
  output logic [7:0]  cfg_data_format
);

  logic csn_s, csn_fall, csn_rise_unused;
  logic sclk_unused, sclk_rise, sclk_fall;
  logic sdi_s, sdi_rise_unused, sdi_fall_unused;

  spi_sync_edge #(.Stages(SYNC_STAGES), .ResetVal(1'b1), .EdgeEn(1'b1)) u_sync_csn (
    .clk_i (clk),
    .rst_ni(reset_n),
    .d_i   (spi_csn),
    .q_o   (csn_s),
    .rise_o(csn_rise_unused),
    .fall_o(csn_fall)
  );

  spi_sync_edge #(.Stages(SYNC_STAGES), .ResetVal(1'b1), .EdgeEn(1'b1)) u_sync_sclk (
    .clk_i (clk),
    .rst_ni(reset_n),
    .d_i   (spi_sclk),
    .q_o   (sclk_unused),
    .rise_o(sclk_rise),
    .fall_o(sclk_fall)
  );

  spi_sync_edge #(.Stages(SYNC_STAGES), .ResetVal(1'b0), .EdgeEn(1'b0)) u_sync_sdi (
    .clk_i (clk),
    .rst_ni(reset_n),
    .d_i   (spi_sdi),
    .q_o   (sdi_s),
    .rise_o(sdi_rise_unused),
    .fall_o(sdi_fall_unused)
  );

  state_e      state_q, state_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  rx_q, rx_d, tx_q, tx_d;
  logic        sdo_q, sdo_d, rw_q, rw_d, mb_q, mb_d;
  logic [5:0]  addr_q, addr_d;
  logic [7:0]  bw_rate_q, bw_rate_d, power_ctl_q, power_ctl_d;
  logic [7:0]  int_enable_q, int_enable_d, data_format_q, data_format_d;
  logic [15:0] live_x_q, live_x_d, live_y_q, live_y_d, live_z_q, live_z_d;
  logic [15:0] shad_x_q, shad_x_d, shad_y_q, shad_y_d, shad_z_q, shad_z_d;
  logic        data_ready_q, data_ready_d, int1_q;

  logic [7:0] rx_next, rd_data;
  logic [5:0] cmd_addr, next_addr, rd_addr;
  logic       dr_clear;

  assign rx_next   = {rx_q[6:0], sdi_s};
  assign cmd_addr  = rx_next[5:0];
  assign next_addr = mb_q ? addr_q + 6'd1 : addr_q;
  // TX reload happens either at the end of the command byte or at the end of a data byte.
  assign rd_addr   = (state_q == StCmd) ? cmd_addr : next_addr;

  always_comb begin
    rd_data = 8'h00;
    case (rd_addr)
      ADDR_DEVID:       rd_data = DEVID;
      ADDR_BW_RATE:     rd_data = bw_rate_q;
      ADDR_POWER_CTL:   rd_data = power_ctl_q;
      ADDR_INT_ENABLE:  rd_data = int_enable_q;
      ADDR_INT_SOURCE:  rd_data = 8'(data_ready_q) << INT_DATA_READY_BIT;
      ADDR_DATA_FORMAT: rd_data = data_format_q;
      ADDR_DATAX0:      rd_data = shad_x_q[7:0];
      ADDR_DATAX1:      rd_data = shad_x_q[15:8];
      ADDR_DATAY0:      rd_data = shad_y_q[7:0];
      ADDR_DATAY1:      rd_data = shad_y_q[15:8];
      ADDR_DATAZ0:      rd_data = shad_z_q[7:0];
      ADDR_DATAZ1:      rd_data = shad_z_q[15:8];
      default:          rd_data = 8'h00;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    rx_d          = rx_q;
    tx_d          = tx_q;
    sdo_d         = sdo_q;
    rw_d          = rw_q;
    mb_d          = mb_q;
    addr_d        = addr_q;
    bw_rate_d     = bw_rate_q;
    power_ctl_d   = power_ctl_q;
    int_enable_d  = int_enable_q;
    data_format_d = data_format_q;
    live_x_d      = live_x_q;
    live_y_d      = live_y_q;
    live_z_d      = live_z_q;
    shad_x_d      = shad_x_q;
    shad_y_d      = shad_y_q;
    shad_z_d      = shad_z_q;
    dr_clear      = 1'b0;

    if (sample_valid) begin
      live_x_d = sample_x;
      live_y_d = sample_y;
      live_z_d = sample_z;
    end

    unique case (state_q)
      StIdle: begin
        if (csn_fall) begin
          state_d   = StCmd;
          bit_cnt_d = 3'd0;
          shad_x_d  = live_x_q;
          shad_y_d  = live_y_q;
          shad_z_d  = live_z_q;
        end
      end
      StCmd: begin
        if (sclk_rise) begin
          rx_d      = rx_next;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d = StData;
            rw_d    = rx_next[7];
            mb_d    = rx_next[6];
            addr_d  = cmd_addr;
            tx_d    = rd_data;
          end
        end
      end
      StData: begin
        if (sclk_fall && rw_q) begin
          sdo_d = tx_q[7];
          tx_d  = {tx_q[6:0], 1'b1};
        end
        if (sclk_rise) begin
          rx_d      = rx_next;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            if (!rw_q) begin
              case (addr_q)
                ADDR_BW_RATE:     bw_rate_d     = rx_next;
                ADDR_POWER_CTL:   power_ctl_d   = rx_next;
                ADDR_INT_ENABLE:  int_enable_d  = rx_next;
                ADDR_DATA_FORMAT: data_format_d = rx_next;
                default: ;
              endcase
            end else begin
              dr_clear = is_data_addr(addr_q);
              tx_d     = rd_data;
            end
            addr_d = next_addr;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Deselect wins over everything: partial bytes are dropped and SDO parks high.
    if (csn_s) begin
      state_d   = StIdle;
      bit_cnt_d = 3'd0;
      sdo_d     = 1'b1;
    end

    data_ready_d = data_ready_q;
    if (dr_clear) data_ready_d = 1'b0;
    if (sample_valid && power_ctl_q[POWER_CTL_MEASURE_BIT]) data_ready_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= StIdle;
      bit_cnt_q     <= 3'd0;
      rx_q          <= 8'h00;
      tx_q          <= 8'hFF;
      sdo_q         <= 1'b1;
      rw_q          <= 1'b0;
      mb_q          <= 1'b0;
      addr_q        <= 6'h00;
      bw_rate_q     <= RST_BW_RATE;
      power_ctl_q   <= RST_POWER_CTL;
      int_enable_q  <= RST_INT_ENABLE;
      data_format_q <= RST_DATA_FORMAT;
      live_x_q      <= 16'h0000;
      live_y_q      <= 16'h0000;
      live_z_q      <= 16'h0000;
      shad_x_q      <= 16'h0000;
      shad_y_q      <= 16'h0000;
      shad_z_q      <= 16'h0000;
      data_ready_q  <= 1'b0;
      int1_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      rx_q          <= rx_d;
      tx_q          <= tx_d;
      sdo_q         <= sdo_d;
      rw_q          <= rw_d;
      mb_q          <= mb_d;
      addr_q        <= addr_d;
      bw_rate_q     <= bw_rate_d;
      power_ctl_q   <= power_ctl_d;
      int_enable_q  <= int_enable_d;
      data_format_q <= data_format_d;
      live_x_q      <= live_x_d;
      live_y_q      <= live_y_d;
      live_z_q      <= live_z_d;
      shad_x_q      <= shad_x_d;
      shad_y_q      <= shad_y_d;
      shad_z_q      <= shad_z_d;
      data_ready_q  <= data_ready_d;
      int1_q        <= data_ready_q & int_enable_q[INT_DATA_READY_BIT];
    end
  end

  assign spi_sdo         = sdo_q;
  assign spi_sdo_oe      = (state_q == StData) && rw_q && !csn_s;
  assign int1            = int1_q;
  assign cfg_bw_rate     = bw_rate_q;
  assign cfg_power_ctl   = power_ctl_q;
  assign cfg_int_enable  = int_enable_q;
  assign cfg_data_format = data_format_q;

endmodule

// File: tb/tb_spi_accel_responder.sv
// Drives a mode-3 SPI master against the responder and checks it against a transaction-level model.
module tb_spi_accel_responder;

  localparam int Half = 6;  // SCLK half period in system clocks (12x oversampling)

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        spi_csn = 1'b1, spi_sclk = 1'b1, spi_sdi = 1'b1;
  logic        spi_sdo, spi_sdo_oe, int1;
  logic [15:0] sample_x = '0, sample_y = '0, sample_z = '0;
  logic        sample_valid = 1'b0;
  logic [7:0]  cfg_bw_rate, cfg_power_ctl, cfg_int_enable, cfg_data_format;

  spi_accel_responder dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .spi_csn        (spi_csn),
    .spi_sclk       (spi_sclk),
    .spi_sdi        (spi_sdi),
    .spi_sdo        (spi_sdo),
    .spi_sdo_oe     (spi_sdo_oe),
    .sample_x       (sample_x),
    .sample_y       (sample_y),
    .sample_z       (sample_z),
    .sample_valid   (sample_valid),
    .int1           (int1),
    .cfg_bw_rate    (cfg_bw_rate),
    .cfg_power_ctl  (cfg_power_ctl),
    .cfg_int_enable (cfg_int_enable),
    .cfg_data_format(cfg_data_format)
  );

  always #20 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: register contents and sample bytes, updated per completed transaction step.
  logic [7:0] m_bw, m_pwr, m_inten, m_fmt;
  logic [7:0] m_live[6];
  logic [7:0] m_shad[6];
  logic       m_dr;

  task automatic m_reset();
    m_bw = 8'h0A; m_pwr = 8'h00; m_inten = 8'h00; m_fmt = 8'h00; m_dr = 1'b0;
    for (int i = 0; i < 6; i++) begin
      m_live[i] = 8'h00;
      m_shad[i] = 8'h00;
    end
  endtask

  function automatic logic [7:0] m_read(input logic [5:0] a);
    int ia = int'(a);
    if (ia == 'h00) return 8'hE5;
    if (ia == 'h2C) return m_bw;
    if (ia == 'h2D) return m_pwr;
    if (ia == 'h2E) return m_inten;
    if (ia == 'h30) return {m_dr, 7'b0};
    if (ia == 'h31) return m_fmt;
    if (ia >= 'h32 && ia <= 'h37) return m_shad[ia - 'h32];
    return 8'h00;
  endfunction

  function automatic bit m_is_data(input logic [5:0] a);
    return (int'(a) >= 'h32) && (int'(a) <= 'h37);
  endfunction

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_cfg(input string tag);
    check_eq({tag, "_bw"}, cfg_bw_rate, m_bw);
    check_eq({tag, "_pwr"}, cfg_power_ctl, m_pwr);
    check_eq({tag, "_inten"}, cfg_int_enable, m_inten);
    check_eq({tag, "_fmt"}, cfg_data_format, m_fmt);
  endtask

  task automatic xfer_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx,
                           output logic oe_all, output logic oe_any);
    rx = 8'h00; oe_all = 1'b1; oe_any = 1'b0;
    for (int i = 7; i > 7 - nbits; i--) begin
      spi_sclk = 1'b0;
      spi_sdi  = tx[i];
      clks(Half);
      spi_sclk = 1'b1;
      rx[i]    = spi_sdo;
      oe_all   = oe_all & spi_sdo_oe;
      oe_any   = oe_any | spi_sdo_oe;
      clks(Half);
    end
  endtask

  task automatic spi_begin();
    spi_csn = 1'b0;
    m_shad  = m_live;
    clks(4);
  endtask

  task automatic spi_end();
    spi_csn = 1'b1;
    spi_sdi = 1'b1;
    clks(6);
    check_eq("end_oe", spi_sdo_oe, 1'b0);
    check_eq("end_sdo", spi_sdo, 1'b1);
  endtask

  task automatic pulse_sample(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
    sample_x = x; sample_y = y; sample_z = z; sample_valid = 1'b1;
    clks(1);
    sample_valid = 1'b0;
    m_live[0] = x[7:0]; m_live[1] = x[15:8];
    m_live[2] = y[7:0]; m_live[3] = y[15:8];
    m_live[4] = z[7:0]; m_live[5] = z[15:8];
    if (m_pwr[3]) m_dr = 1'b1;
    clks(3);
    check_eq("smp_int1", int1, m_dr & m_inten[7]);
  endtask

  task automatic write_txn(input logic [5:0] addr, input logic [7:0] data, input int nbits);
    logic [7:0] rx;
    logic oe_all, oe_any;
    spi_begin();
    xfer_bits({2'b00, addr}, 8, rx, oe_all, oe_any);
    xfer_bits(data, nbits, rx, oe_all, oe_any);
    check_eq("wr_oe", oe_any, 1'b0);
    if (nbits == 8) begin
      case (int'(addr))
        'h2C: m_bw = data;
        'h2D: m_pwr = data;
        'h2E: m_inten = data;
        'h31: m_fmt = data;
        default: ;
      endcase
      check_cfg("wr_pre");
    end
    spi_end();
    check_cfg("wr_post");
  endtask

  task automatic read_txn(input logic [5:0] addr, input bit mb, input int n, input int mid,
                          input logic [15:0] mx, input logic [15:0] my, input logic [15:0] mz);
    logic [7:0] rx, exp;
    logic oe_all, oe_any;
    logic [5:0] a;
    a = addr;
    spi_begin();
    xfer_bits({1'b1, mb, addr}, 8, rx, oe_all, oe_any);
    check_eq("cmd_oe", oe_any, 1'b0);
    for (int k = 0; k < n; k++) begin
      if (k == mid) pulse_sample(mx, my, mz);
      xfer_bits(8'h00, 8, rx, oe_all, oe_any);
      exp = m_read(a);
      if (m_is_data(a)) m_dr = 1'b0;
      check_eq($sformatf("rd@%02h", a), rx, exp);
      check_eq("rd_oe", oe_all, 1'b1);
      check_eq("rd_int1", int1, m_dr & m_inten[7]);
      if (mb) a = a + 6'd1;
    end
    spi_end();
  endtask

  function automatic logic [5:0] pick_addr();
    logic [5:0] list[8];
    list = '{6'h00, 6'h2C, 6'h2D, 6'h2E, 6'h30, 6'h31, 6'h32, 6'h3F};
    if ($urandom_range(0, 1) == 0) return list[$urandom_range(0, 7)];
    return 6'($urandom_range(0, 63));
  endfunction

  initial begin
    logic [7:0] rx;
    logic oe_all, oe_any;
    int n, mid;

    m_reset();
    clks(3);
    check_eq("rst_oe", spi_sdo_oe, 1'b0);
    check_eq("rst_sdo", spi_sdo, 1'b1);
    check_eq("rst_int1", int1, 1'b0);
    check_cfg("rst");
    reset_n = 1'b1;
    clks(4);

    // DEVID, config write/readback, write to a read-only data register.
    read_txn(6'h00, 1'b0, 1, -1, '0, '0, '0);
    write_txn(6'h2D, 8'h08, 8);
    read_txn(6'h2D, 1'b0, 1, -1, '0, '0, '0);
    write_txn(6'h33, 8'hFF, 8);
    read_txn(6'h32, 1'b1, 6, -1, '0, '0, '0);

    // Data-ready interrupt and little-endian burst.
    write_txn(6'h2E, 8'h80, 8);
    pulse_sample(16'h1234, 16'hFFF0, 16'h0100);
    check_eq("int1_set", int1, 1'b1);
    read_txn(6'h32, 1'b1, 6, -1, '0, '0, '0);

    // Sample mid-burst: burst keeps the frozen shadow, next transaction sees the new value.
    read_txn(6'h32, 1'b1, 6, 0, 16'hABCD, 16'h1111, 16'h2222);
    read_txn(6'h32, 1'b1, 2, -1, '0, '0, '0);

    // Aborted write, then the responder must answer cleanly.
    write_txn(6'h31, 8'h55, 5);
    read_txn(6'h00, 1'b0, 1, -1, '0, '0, '0);

    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 4))
        0: write_txn(($urandom_range(0, 1) == 0) ? pick_addr() : 6'h2D,
                     8'($urandom_range(0, 255)), 8);
        1: read_txn(pick_addr(), 1'($urandom_range(0, 1)), 1, -1, '0, '0, '0);
        2: begin
          n   = int'($urandom_range(1, 4));
          mid = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, n - 1)) : -1;
          read_txn(pick_addr(), 1'($urandom_range(0, 1)), n, mid, 16'($urandom),
                   16'($urandom), 16'($urandom));
        end
        3: pulse_sample(16'($urandom), 16'($urandom), 16'($urandom));
        default: write_txn(pick_addr(), 8'($urandom_range(0, 255)), int'($urandom_range(1, 7)));
      endcase
    end

    // Address wrap 0x3F -> 0x00, then asynchronous reset in the middle of the burst.
    write_txn(6'h2C, 8'h0F, 8);
    write_txn(6'h31, 8'h0B, 8);
    write_txn(6'h2E, 8'h80, 8);
    spi_begin();
    xfer_bits(8'hFF, 8, rx, oe_all, oe_any);
    xfer_bits(8'h00, 8, rx, oe_all, oe_any);
    check_eq("wrap_3f", rx, 8'h00);
    xfer_bits(8'h00, 8, rx, oe_all, oe_any);
    check_eq("wrap_00", rx, 8'hE5);
    xfer_bits(8'h00, 3, rx, oe_all, oe_any);
    #3 reset_n = 1'b0;
    #1;
    m_reset();
    check_eq("arst_oe", spi_sdo_oe, 1'b0);
    check_eq("arst_sdo", spi_sdo, 1'b1);
    check_eq("arst_int1", int1, 1'b0);
    check_cfg("arst");
    spi_csn  = 1'b1;
    spi_sclk = 1'b1;
    clks(3);
    reset_n = 1'b1;
    clks(4);
    read_txn(6'h00, 1'b0, 1, -1, '0, '0, '0);
    read_txn(6'h2C, 1'b1, 1, -1, '0, '0, '0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
